// File: rtl/pipe_dmem_pkg.sv
// Shared types and constants for the pipeline data-memory interface.
// Holds the FSM encoding, the MEM/WB and hold record layouts and the default watchdog limit.
package pipe_dmem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    localparam int TIMEOUT_DEF = 16;

    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [4:0]  wn;
        logic [31:0] alu;
        logic [31:0] di;
    } hold_t;

    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic [4:0]  wn;
        logic [31:0] alu;
        logic [31:0] mem;
    } wb_t;

    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/pipe_dmem_wdog.sv
// Watchdog counter for a pending bus access: counts WAIT cycles without ack.
// expired_o is combinational and rises in the TIMEOUT-th WAIT cycle.
module pipe_dmem_wdog
    import pipe_dmem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic clrn,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the number of completed ack-less WAIT cycles before this one
    assign expired_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/pipe_dmem_if.sv
// EX/MEM-to-WB stage with a blocking single-outstanding data-memory bus access.
// Optional watchdog abort when DMEM_TIMEOUT_EN is defined.
module pipe_dmem_if
    import pipe_dmem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        ex_wreg,
    input  logic        ex_m2reg,
    input  logic        ex_wmem,
    input  logic [4:0]  ex_wn,
    input  logic [31:0] ex_alu,
    input  logic [31:0] ex_di,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        wb_wreg,
    output logic        wb_m2reg,
    output logic [4:0]  wb_wn,
    output logic [31:0] wb_alu,
    output logic [31:0] wb_mem,
    output logic        err_misalign,
    output logic        err_timeout
);

    state_e state_q, state_d;
    hold_t  hold_q;
    wb_t    wb_q;
    logic   err_misalign_q;
    logic   timeout_hit;

    logic in_idle, in_wait, acc, start, misalign, done, abort;

    assign in_idle  = (state_q == IDLE);
    assign in_wait  = (state_q == WAIT);
    assign acc      = ex_m2reg | ex_wmem;
    assign start    = in_idle & acc & is_word_aligned(ex_alu[1:0]);
    assign misalign = in_idle & acc & ~is_word_aligned(ex_alu[1:0]);
    assign done     = in_wait & mem_ack;
    assign abort    = in_wait & ~mem_ack & timeout_hit;

`ifdef DMEM_TIMEOUT_EN
    logic err_timeout_q;

    pipe_dmem_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk       (clk),
        .clrn      (clrn),
        .clr_i     (start),
        .inc_i     (in_wait & ~mem_ack),
        .expired_o (timeout_hit)
    );

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            err_timeout_q <= 1'b0;
        end else if (abort) begin
            err_timeout_q <= 1'b1;
        end
    end

    assign err_timeout = err_timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = WAIT;
            WAIT:    if (mem_ack || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus is driven only from the hold record so ex_* may change freely during WAIT
    always_comb begin
        mem_req   = in_wait;
        mem_we    = in_wait & hold_q.wmem;
        mem_addr  = in_wait ? hold_q.alu : '0;
        mem_wdata = in_wait ? hold_q.di  : '0;
        stall     = ~clrn & (start | (in_wait & ~mem_ack & ~timeout_hit));
    end

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            hold_q <= '0;
        end else if (start) begin
            hold_q <= '{wreg: ex_wreg, m2reg: ex_m2reg, wmem: ex_wmem,
                        wn: ex_wn, alu: ex_alu, di: ex_di};
        end
    end

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            wb_q <= '0;
        end else if (in_idle && !acc) begin
            wb_q <= '{wreg: ex_wreg, m2reg: ex_m2reg, wn: ex_wn, alu: ex_alu, mem: 32'h0};
        end else if (done) begin
            wb_q <= '{wreg: hold_q.wreg, m2reg: hold_q.m2reg, wn: hold_q.wn, alu: hold_q.alu,
                      mem: hold_q.m2reg ? mem_rdata : 32'h0};
        end else begin
            wb_q <= '0;
        end
    end

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            err_misalign_q <= 1'b0;
        end else if (misalign) begin
            err_misalign_q <= 1'b1;
        end
    end

    assign wb_wreg      = wb_q.wreg;
    assign wb_m2reg     = wb_q.m2reg;
    assign wb_wn        = wb_q.wn;
    assign wb_alu       = wb_q.alu;
    assign wb_mem       = wb_q.mem;
    assign err_misalign = err_misalign_q;

endmodule
